// File: rtl/dual_port_regfile.sv
// ---------------------------------------------------------------------------
// dual_port_regfile
//
// Register file with two symmetric ports, R (source) and D (destination).
// Each port has its own address, chip select, write enable, output enable
// and one bidirectional data bus. Reads are combinational. Writes happen on
// the rising clock edge.
//
// Optional feature macro: DUAL_PORT_REGFILE_DEBUG_EN
//   When it is defined, the debug_register_Y output exists. It carries the
//   Y pointer {r29, r28}, truncated to Y_WIDTH bits. When it is undefined,
//   the port and its logic are absent. Nothing else changes.
//
// Parameters
//   DATA_WIDTH : register width in bits
//   ADDR_WIDTH : address width (2**ADDR_WIDTH registers)
//   Y_WIDTH    : width of the debug Y pointer (1 .. 2*DATA_WIDTH)
//
// Ports
//   clk              in   : single clock; all state changes on its rising edge
//   reset            in   : synchronous, active-high; clears every register
//   rr_addr, rd_addr in   : port R / port D register address
//   rr_data, rd_data inout: port R / port D bidirectional data bus
//   rr_cs,   rd_cs   in   : per-port chip select
//   rr_we,   rd_we   in   : per-port write enable (a write ignores oe)
//   rr_oe,   rd_oe   in   : per-port output enable
//   debug_register_Y out  : {r29, r28}[Y_WIDTH-1:0] (debug builds only)
//
// Bus protocol for each port P
//   Read : P_cs=1, P_oe=1, P_we=0. The port drives P_data with reg[P_addr]
//          in the same cycle.
//   Write: P_cs=1, P_we=1. The external master drives P_data. The value is
//          captured on the rising edge. The port never drives the bus while
//          P_we=1.
//   Idle : in every other case the port releases the bus to high-Z.
// ---------------------------------------------------------------------------
module dual_port_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int Y_WIDTH    = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    inout  wire  [DATA_WIDTH-1:0] rr_data,
    inout  wire  [DATA_WIDTH-1:0] rd_data,
    input  logic                  rr_cs,
    input  logic                  rd_cs,
    input  logic                  rr_we,
    input  logic                  rd_we,
    input  logic                  rr_oe,
    input  logic                  rd_oe
`ifdef DUAL_PORT_REGFILE_DEBUG_EN
    ,
    output logic [Y_WIDTH-1:0]    debug_register_Y
`endif
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // -----------------------------------------------------------------------
    // Per-port access decode
    // -----------------------------------------------------------------------
    logic rr_read;
    logic rd_read;
    logic rr_write;
    logic rd_write;

    always_comb begin
        rr_read  = 1'b0;
        rd_read  = 1'b0;
        rr_write = 1'b0;
        rd_write = 1'b0;

        // A write takes precedence over the output enable. This keeps the
        // port off the bus while the master drives the write data.
        rr_write = rr_cs && rr_we;
        rd_write = rd_cs && rd_we;
        rr_read  = rr_cs && rr_oe && !rr_we;
        rd_read  = rd_cs && rd_oe && !rd_we;
    end

    // -----------------------------------------------------------------------
    // Combinational read path
    // These paths read the registers directly. A read that overlaps a write
    // to the same address therefore returns the old value until the edge
    // and the new value right after it. Reads stay live during reset.
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rr_rdata;
    logic [DATA_WIDTH-1:0] rd_rdata;

    always_comb begin
        rr_rdata = regs[rr_addr];
        rd_rdata = regs[rd_addr];
    end

    assign rr_data = rr_read ? rr_rdata : {DATA_WIDTH{1'bz}};
    assign rd_data = rd_read ? rd_rdata : {DATA_WIDTH{1'bz}};

    // -----------------------------------------------------------------------
    // Write path
    // Reset wins over any write in the same cycle. When both ports write the
    // same address, port D's assignment comes last, so D's value is stored.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (rr_write) begin
                regs[rr_addr] <= rr_data;
            end
            if (rd_write) begin
                regs[rd_addr] <= rd_data;
            end
        end
    end

`ifdef DUAL_PORT_REGFILE_DEBUG_EN
    // -----------------------------------------------------------------------
    // Debug Y pointer: r29 is the high byte and r28 the low byte. With fewer
    // than 30 registers the pointer has no backing storage and reads 0.
    // -----------------------------------------------------------------------
    generate
        if (ADDR_WIDTH >= 5) begin : g_y_ptr
            assign debug_register_Y = Y_WIDTH'({regs[29], regs[28]});
        end else begin : g_y_zero
            assign debug_register_Y = '0;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_dual_port_regfile.sv
// ---------------------------------------------------------------------------
// tb_dual_port_regfile
//
// Directed bench for dual_port_regfile with default parameters.
//
// Each bus has a pull-up. A released bus therefore reads 8'hFF. The stored
// values used in the checks are never 8'hFF while a release is being
// checked, so a port that drives the bus when it should not is visible.
//
// A driver issues one cycle of port settings. For cycles that need a check,
// it queues the expected {rr_data, rd_data, Y}. A monitor on the falling
// edge pops one entry and compares it with the buses.
// ---------------------------------------------------------------------------
module tb_dual_port_regfile;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int YW = 7;
    localparam logic [DW-1:0] REL = 8'hFF;   // released bus (pull-up)

    // ---------------- clock / reset -----------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b0;
    logic [AW-1:0] rr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic          rr_cs = 1'b0;
    logic          rd_cs = 1'b0;
    logic          rr_we = 1'b0;
    logic          rd_we = 1'b0;
    logic          rr_oe = 1'b0;
    logic          rd_oe = 1'b0;
    logic          r_drv = 1'b0;
    logic          d_drv = 1'b0;
    logic [DW-1:0] r_wd = '0;
    logic [DW-1:0] d_wd = '0;
    wire  [DW-1:0] rr_data;
    wire  [DW-1:0] rd_data;
`ifdef DUAL_PORT_REGFILE_DEBUG_EN
    logic [YW-1:0] debug_register_Y;
`endif

    pullup (rr_data);
    pullup (rd_data);

    assign rr_data = r_drv ? r_wd : {DW{1'bz}};
    assign rd_data = d_drv ? d_wd : {DW{1'bz}};

    dual_port_regfile #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .Y_WIDTH   (YW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rr_addr (rr_addr),
        .rd_addr (rd_addr),
        .rr_data (rr_data),
        .rd_data (rd_data),
        .rr_cs   (rr_cs),
        .rd_cs   (rd_cs),
        .rr_we   (rr_we),
        .rd_we   (rd_we),
        .rr_oe   (rr_oe),
        .rd_oe   (rd_oe)
`ifdef DUAL_PORT_REGFILE_DEBUG_EN
        ,
        .debug_register_Y(debug_register_Y)
`endif
    );

    // ---------------- scoreboard --------------------------------------------
    logic [23:0] exp_q[$];
    string       name_q[$];
    logic        sample_valid = 1'b0;
    int          checks = 0;
    int          passed = 0;

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        logic [23:0] e;
        string nm;
        if (sample_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL no_expectation: got sample expected queued entry");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check8({nm, "_rr"}, rr_data, e[23:16]);
                check8({nm, "_rd"}, rd_data, e[15:8]);
`ifdef DUAL_PORT_REGFILE_DEBUG_EN
                check8({nm, "_y"}, {1'b0, debug_register_Y}, e[7:0]);
`endif
            end
        end
    end

    // ---------------- driver tasks ------------------------------------------
    // One full cycle. The inputs change just after a rising edge and stay
    // valid until the next rising edge. The monitor samples in between.
    task automatic drive(
        input string nm, input logic rst,
        input logic rcs, input logic rwe, input logic roe, input logic rdrv,
        input logic [AW-1:0] ra, input logic [DW-1:0] rwd,
        input logic dcs, input logic dwe, input logic doe, input logic ddrv,
        input logic [AW-1:0] da, input logic [DW-1:0] dwd,
        input logic chk, input logic [7:0] er, input logic [7:0] ed, input logic [7:0] ey);
        reset = rst;
        rr_cs = rcs; rr_we = rwe; rr_oe = roe; r_drv = rdrv; rr_addr = ra; r_wd = rwd;
        rd_cs = dcs; rd_we = dwe; rd_oe = doe; d_drv = ddrv; rd_addr = da; d_wd = dwd;
        if (chk) begin
            exp_q.push_back({er, ed, ey});
            name_q.push_back(nm);
        end
        sample_valid = chk;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic rd2(input string nm, input logic [AW-1:0] ra, input logic [AW-1:0] da,
                       input logic [7:0] er, input logic [7:0] ed, input logic [7:0] ey);
        drive(nm, 0, 1, 0, 1, 0, ra, 8'h00, 1, 0, 1, 0, da, 8'h00, 1, er, ed, ey);
    endtask

    task automatic wr_r(input logic [AW-1:0] a, input logic [7:0] d);
        drive("wr_r", 0, 1, 1, 0, 1, a, d, 0, 0, 0, 0, 5'd0, 8'h00, 0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic wr_d(input logic [AW-1:0] a, input logic [7:0] d);
        drive("wr_d", 0, 0, 0, 0, 0, 5'd0, 8'h00, 1, 1, 0, 1, a, d, 0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic wr_both(input logic [AW-1:0] ra, input logic [7:0] rdat,
                           input logic [AW-1:0] da, input logic [7:0] ddat);
        drive("wr_both", 0, 1, 1, 0, 1, ra, rdat, 1, 1, 0, 1, da, ddat, 0, 8'h00, 8'h00, 8'h00);
    endtask

    // ---------------- stimulus ----------------------------------------------
    initial begin
        @(posedge clk);
        #1;
        // First reset edge defines the contents.
        drive("rst0", 1, 0, 0, 0, 0, 5'd0, 8'h00, 0, 0, 0, 0, 5'd0, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        rd2("after_reset", 5'd0, 5'd31, 8'h00, 8'h00, 8'h00);

        // Reset clears a written register. Reads stay live during reset.
        wr_d(5'd3, 8'hA5);
        rd2("r3_written", 5'd3, 5'd3, 8'hA5, 8'hA5, 8'h00);
        drive("read_in_reset", 1, 1, 0, 1, 0, 5'd3, 8'h00, 1, 0, 1, 0, 5'd3, 8'h00,
              1, 8'hA5, 8'hA5, 8'h00);
        rd2("r3_cleared", 5'd3, 5'd3, 8'h00, 8'h00, 8'h00);

        // Single write, dual read of the same address.
        wr_d(5'd17, 8'h3C);
        rd2("dual_read17", 5'd17, 5'd17, 8'h3C, 8'h3C, 8'h00);

        // Write collision: port D wins.
        wr_both(5'd5, 8'h11, 5'd5, 8'h22);
        rd2("collision_r5", 5'd5, 5'd5, 8'h22, 8'h22, 8'h00);

        // Write through port R. Independent reads of different addresses.
        wr_r(5'd10, 8'h96);
        rd2("indep_read", 5'd10, 5'd17, 8'h96, 8'h3C, 8'h00);

        // Read during write: port R sees the old value until the edge.
        drive("rdw_old", 0, 1, 0, 1, 0, 5'd10, 8'h00, 1, 1, 1, 1, 5'd10, 8'h4B,
              1, 8'h96, 8'h4B, 8'h00);
        rd2("rdw_new", 5'd10, 5'd10, 8'h4B, 8'h4B, 8'h00);

        // Tristate cases, using r9 = 5A.
        wr_d(5'd9, 8'h5A);
        drive("rr_cs0", 0, 0, 0, 1, 0, 5'd9, 8'h00, 1, 0, 1, 0, 5'd9, 8'h00, 1, REL, 8'h5A, 8'h00);
        drive("rr_oe0", 0, 1, 0, 0, 0, 5'd9, 8'h00, 1, 0, 1, 0, 5'd9, 8'h00, 1, REL, 8'h5A, 8'h00);
        drive("rr_we1", 0, 0, 1, 1, 0, 5'd9, 8'h00, 1, 0, 1, 0, 5'd9, 8'h00, 1, REL, 8'h5A, 8'h00);
        drive("rd_cs0", 0, 1, 0, 1, 0, 5'd9, 8'h00, 0, 0, 1, 0, 5'd9, 8'h00, 1, 8'h5A, REL, 8'h00);
        drive("rd_oe0", 0, 1, 0, 1, 0, 5'd9, 8'h00, 1, 0, 0, 0, 5'd9, 8'h00, 1, 8'h5A, REL, 8'h00);
        drive("rd_we1", 0, 1, 0, 1, 0, 5'd9, 8'h00, 0, 1, 1, 0, 5'd9, 8'h00, 1, 8'h5A, REL, 8'h00);
        // Selected write with oe=1 and nobody driving: the port stays off the
        // bus, and the pulled-up bus value is stored.
        drive("rr_wr_oe1", 0, 1, 1, 1, 0, 5'd9, 8'h00, 1, 0, 1, 0, 5'd9, 8'h00, 1, REL, 8'h5A, 8'h00);
        rd2("r9_pulled", 5'd9, 5'd9, 8'hFF, 8'hFF, 8'h00);

        // Address boundaries.
        wr_both(5'd0, 8'h01, 5'd31, 8'h80);
        rd2("boundary", 5'd31, 5'd0, 8'h80, 8'h01, 8'h00);

        // Selected but neither writing nor reading: no change.
        drive("no_write", 0, 1, 0, 0, 0, 5'd17, 8'h00, 1, 0, 0, 0, 5'd5, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        rd2("held", 5'd17, 5'd5, 8'h3C, 8'h22, 8'h00);

        // Reset has priority over a simultaneous port D write of 77 to r0.
        drive("rst_prio", 1, 1, 0, 1, 0, 5'd0, 8'h00, 1, 1, 0, 1, 5'd0, 8'h77, 1, 8'h01, 8'h77, 8'h00);
        rd2("r0_after_prio", 5'd0, 5'd17, 8'h00, 8'h00, 8'h00);

        // Debug pointer: r28=F4, r29=01 -> {01,F4}[6:0] = 74.
        wr_both(5'd29, 8'h01, 5'd28, 8'hF4);
        rd2("y_ptr", 5'd28, 5'd29, 8'hF4, 8'h01, 8'h74);

        drive("idle", 0, 0, 0, 0, 0, 5'd0, 8'h00, 0, 0, 0, 0, 5'd0, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dual_port_regfile.md
DUAL_PORT_REGFILE -- requirements
Module: dual_port_regfile

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: register width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: address width, giving 2^ADDR_WIDTH registers.
REQ-003 SHALL have parameter Y_WIDTH, default 7: width of the debug Y-pointer output (1..2*DATA_WIDTH).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL have port rr_addr, input, ADDR_WIDTH: port R (source) register address.
REQ-007 SHALL have port rd_addr, input, ADDR_WIDTH: port D (destination) register address.
REQ-008 SHALL have port rr_data, inout, DATA_WIDTH: port R bidirectional data bus.
REQ-009 SHALL have port rd_data, inout, DATA_WIDTH: port D bidirectional data bus.
REQ-010 SHALL have ports rr_cs and rd_cs, input, 1 bit each: per-port chip select.
REQ-011 SHALL have ports rr_we and rd_we, input, 1 bit each: per-port write enable.
REQ-012 SHALL have ports rr_oe and rd_oe, input, 1 bit each: per-port output enable.
REQ-013 SHALL have port debug_register_Y, output, Y_WIDTH: Y pointer {r29,r28} truncated to its low Y_WIDTH bits (present only per REQ-029).

Function
REQ-014 SHALL contain 2^ADDR_WIDTH registers of DATA_WIDTH bits, all addressable from both ports.
REQ-015 SHALL read combinationally: port P drives P_data with reg[P_addr] whenever P_cs=1, P_oe=1 and P_we=0, in the same cycle and with no clock latency.
REQ-016 SHALL release port P's data bus to high-Z whenever P_cs=0, P_oe=0 or P_we=1.
REQ-017 SHALL write on the rising clk edge: when P_cs=1 and P_we=1, reg[P_addr] takes the value present on P_data; P_oe is ignored during a write.
REQ-018 SHALL allow both ports to read independently in the same cycle, including the same address; both buses then drive identical data.
REQ-019 SHALL allow both ports to write in the same cycle; if both write the same address, port D's value is stored and port R's is discarded.
REQ-020 SHALL, on read-during-write to the same address (one port writing, the other reading), return the pre-edge (old) value until the edge, then the new value combinationally after it.
REQ-021 SHALL leave registers unchanged in any cycle without a qualifying write.
REQ-022 SHALL ignore out-of-range behaviour: every ADDR_WIDTH address is valid; there is no wrap logic.
REQ-023 SHALL compute debug_register_Y combinationally from r28 (low byte) and r29 (high byte) when ADDR_WIDTH>=5; if fewer registers exist, it SHALL be 0.

Reset
REQ-024 SHALL clear every register to 0 on a rising clk edge with reset=1.
REQ-025 SHALL give reset priority over any simultaneous write; that write is lost.
REQ-026 SHALL keep combinational reads active during reset, so they return the current contents, which are 0 after the first reset edge.
REQ-027 SHALL have debug_register_Y equal to 0 after the reset edge.
REQ-028 SHALL leave the contents undefined before the first reset edge; the bench must apply reset first.

Configuration
REQ-029 SHALL gate the debug_register_Y port and its logic with the macro DUAL_PORT_REGFILE_DEBUG_EN. When the macro is defined, the port exists and follows REQ-023. When it is undefined, the port and its logic are absent and all other behaviour is identical.

Verification
REQ-030 SHALL cover reset: write 0xA5 to r3, then assert reset for one edge -> a read of r3 returns 0x00 on both ports.
REQ-031 SHALL cover a single write and dual read: port D writes 0x3C to r17; next cycle rr_addr=rd_addr=17 with oe=1 -> both buses show 0x3C.
REQ-032 SHALL cover a write collision: in the same edge port R writes 0x11 and port D writes 0x22 to r5 -> r5 reads 0x22.
REQ-033 SHALL cover tristate: rr_cs=0, or rr_oe=0, or rr_we=1 -> rr_data is high-Z; rd_data behaves the same way.
REQ-034 SHALL cover the debug pointer with the macro defined: r28=0xF4, r29=0x01 -> debug_register_Y = 7'h74.
REQ-035 SHALL cover reset priority: reset=1 together with a port D write of 0x77 to r0 -> r0 reads 0x00.
